featuremap_accum: RTL and testbench
===================================

FEATUREMAP_ACCUM -- requirements
Module: featuremap_accum

Interface
REQ-001 Parameter DATA_WIDTH, default 24: width of every sample, signed two's complement fixed point.
REQ-002 Parameter NUM_CH, default 6: number of input-channel partial-sum streams summed into one feature map (range 1..16).
REQ-003 Parameter FIFO_DEPTH, default 4: per-channel skew FIFO depth in entries (power of two, at least 2).
REQ-004 Parameter BIAS, default 0: signed DATA_WIDTH-bit raw bias added to every sum.
REQ-005 Parameter RELU_EN, default 1: 1 clamps negative results to 0; 0 passes signed results unchanged.
REQ-006 Parameter OUT_PIXELS, default 576: number of outputs per frame.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 ch_data  input  NUM_CH*DATA_WIDTH  packed channel samples; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 ch_valid  input  NUM_CH  per-channel sample strobe; bit k qualifies channel k's slice in the same cycle.
REQ-011 data_out  output  DATA_WIDTH  accumulated, biased, saturated, optionally rectified result.
REQ-012 valid_out  output  1  one-cycle strobe qualifying data_out.
REQ-013 frame_done  output  1  one-cycle strobe coincident with the last valid_out of a frame.
REQ-014 sat_flag  output  1  sticky: a result was saturated since reset.
REQ-015 ovf_err  output  1  sticky: a sample was dropped on a full FIFO since reset.

Function
REQ-016 Each channel SHALL have its own FIFO_DEPTH-entry FIFO; ch_valid[k] high pushes ch_data slice k.
REQ-017 A pushed entry SHALL become poppable in the cycle after the push, with no combinational fall-through.
REQ-018 A pop SHALL occur, popping all FIFOs together, in any cycle in which every FIFO is non-empty.
REQ-019 A push to a full FIFO in a cycle with no pop SHALL be dropped and SHALL set ovf_err; push and pop in the same cycle on a full FIFO SHALL accept the push.
REQ-020 Stage 1 SHALL register the sign-extended sum of all popped heads at width DATA_WIDTH+clog2(NUM_CH)+1, with no overflow.
REQ-021 Stage 2 SHALL add sign-extended BIAS, saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], apply ReLU if RELU_EN=1, and register the result into data_out.
REQ-022 sat_flag SHALL set whenever saturation alters a value; saturation is evaluated before ReLU.
REQ-023 Latency: a pop in cycle P SHALL produce valid_out in cycle P+2; an input arriving in cycle T that completes a set of samples SHALL produce valid_out in cycle T+3.
REQ-024 Throughput SHALL be one result per cycle when every channel presents a sample every cycle.
REQ-025 data_out SHALL hold its last value while valid_out is low.
REQ-026 Results SHALL preserve order: the n-th sample of every channel combines into the n-th output.
REQ-027 The output counter SHALL count valid_out pulses modulo OUT_PIXELS; frame_done SHALL pulse with the OUT_PIXELS-th pulse, and the count SHALL wrap to 0.
REQ-028 A channel that runs ahead by up to FIFO_DEPTH samples SHALL lose no data.

Reset
REQ-029 While rst is high at a clock edge, the block SHALL empty all FIFOs, clear the pipeline valids and the output counter, and set data_out=0, valid_out=0, frame_done=0, sat_flag=0 and ovf_err=0.
REQ-030 Reset mid-frame SHALL discard in-flight samples; no valid_out SHALL appear for pre-reset data.
REQ-031 Samples presented in the cycle rst is high SHALL be ignored.

Verification
REQ-032 Defaults; all 6 channels value 1, valid in cycle T -> valid_out in T+3 with data_out=6, no flags.
REQ-033 Channels 0-4 value 2 at T, channel 5 value -1 at T+3 -> single valid_out at T+6 with data_out=9.
REQ-034 All channels 0x7FFFFF -> data_out=0x7FFFFF, sat_flag=1; all 0x800000 with RELU_EN=1 -> data_out=0, sat_flag=1.
REQ-035 Channel 0 alone, 5 consecutive samples (depth 4) -> ovf_err=1 and no valid_out; then 4 samples on channels 1-5 -> exactly 4 outputs.
REQ-036 OUT_PIXELS=4; 9 complete sample sets -> frame_done on outputs 4 and 8 only.
REQ-037 rst asserted with 3 results in flight -> next cycle all outputs 0, no stale valid_out; a fresh input set yields a correct result 3 cycles after its arrival.

Source files
------------

// File: rtl/featuremap_accum.sv
// featuremap_accum: per-channel skew FIFOs feeding a two-stage sum/bias/saturate/ReLU pipeline.
// Output counter marks the last result of each OUT_PIXELS-long frame.
module featuremap_accum #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_CH     = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int BIAS       = 0,
    parameter bit RELU_EN    = 1,
    parameter int OUT_PIXELS = 576
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    input  logic [NUM_CH-1:0]            ch_valid,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    output logic                         frame_done,
    output logic                         sat_flag,
    output logic                         ovf_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = DATA_WIDTH + $clog2(NUM_CH) + 1;
    localparam int CW = OUT_PIXELS > 1 ? $clog2(OUT_PIXELS) : 1;
    localparam logic [DATA_WIDTH-1:0] BIAS_W = DATA_WIDTH'(BIAS);
    localparam logic signed [SW:0] MAX_V = {{(SW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW:0] MIN_V = {{(SW-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    logic [NUM_CH-1:0]            w_empty;
    logic [NUM_CH-1:0]            w_full;
    logic [NUM_CH-1:0]            w_push;
    logic [NUM_CH-1:0]            w_drop;
    logic                         w_pop;
    logic [DATA_WIDTH-1:0]        w_head [NUM_CH];
    logic signed [SW-1:0]         w_sum;
    logic signed [SW-1:0]         r_sum;
    logic                         r_v1;
    logic [CW-1:0]                r_pix;
    logic signed [SW:0]           w_biased;
    logic                         w_hi;
    logic                         w_lo;
    logic [DATA_WIDTH-1:0]        w_sat;
    logic [DATA_WIDTH-1:0]        w_res;
    assign w_pop = ~|w_empty;
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
        logic [AW-1:0]         r_wp;
        logic [AW-1:0]         r_rp;
        logic [AW:0]           r_cnt;
        assign w_empty[k] = r_cnt == '0;
        assign w_full[k]  = r_cnt == (AW+1)'(FIFO_DEPTH);
        // a full FIFO still accepts when the same cycle pops its head
        assign w_push[k]  = ch_valid[k] && (!w_full[k] || w_pop);
        assign w_drop[k]  = ch_valid[k] && w_full[k] && !w_pop;
        assign w_head[k]  = r_mem[r_rp];
        always_ff @(posedge clk) begin
            if (rst) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push[k]) begin
                    r_mem[r_wp] <= ch_data[k*DATA_WIDTH +: DATA_WIDTH];
                    r_wp        <= r_wp + 1'b1;
                end
                if (w_pop) r_rp <= r_rp + 1'b1;
                r_cnt <= r_cnt + (AW+1)'(w_push[k]) - (AW+1)'(w_pop);
            end
        end
    end
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_CH; i++) w_sum = w_sum + SW'($signed(w_head[i]));
    end
    assign w_biased = {r_sum[SW-1], r_sum} + {{(SW+1-DATA_WIDTH){BIAS_W[DATA_WIDTH-1]}}, BIAS_W};
    assign w_hi     = w_biased > MAX_V;
    assign w_lo     = w_biased < MIN_V;
    assign w_sat    = w_hi ? MAX_V[DATA_WIDTH-1:0] : w_lo ? MIN_V[DATA_WIDTH-1:0] : w_biased[DATA_WIDTH-1:0];
    assign w_res    = (RELU_EN && w_sat[DATA_WIDTH-1]) ? '0 : w_sat;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum      <= '0;
            r_v1       <= 1'b0;
            r_pix      <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            sat_flag   <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            r_v1       <= w_pop;
            if (w_pop) r_sum <= w_sum;
            valid_out  <= r_v1;
            frame_done <= r_v1 && r_pix == CW'(OUT_PIXELS-1);
            if (r_v1) begin
                data_out <= w_res;
                r_pix    <= r_pix == CW'(OUT_PIXELS-1) ? '0 : r_pix + 1'b1;
            end
            if (r_v1 && (w_hi || w_lo)) sat_flag <= 1'b1;
            if (|w_drop) ovf_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_featuremap_accum.sv
// tb_featuremap_accum: directed checks of latency, skew, saturation, overflow, framing and reset.
module tb_featuremap_accum;
    localparam int DW = 24;
    localparam int NC = 6;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NC*DW-1:0] ch_data = '0;
    logic [NC-1:0]    ch_valid = '0;
    logic [DW-1:0]    data_out;
    logic             valid_out;
    logic             frame_done;
    logic             sat_flag;
    logic             ovf_err;
    int               checks = 0;
    int               errors = 0;
    int               nvalid = 0;
    int               base;
    logic [DW:0]      q_out [$];
    featuremap_accum #(.DATA_WIDTH(DW), .NUM_CH(NC), .FIFO_DEPTH(4), .BIAS(0), .RELU_EN(1), .OUT_PIXELS(4)) u_dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .ch_valid(ch_valid),
        .data_out(data_out), .valid_out(valid_out), .frame_done(frame_done),
        .sat_flag(sat_flag), .ovf_err(ovf_err)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
        if (valid_out) begin
            nvalid++;
            q_out.push_back({frame_done, data_out});
        end
    endtask
    task automatic drive(input logic [NC-1:0] m, input logic [DW-1:0] v);
        ch_valid = m;
        for (int i = 0; i < NC; i++) ch_data[i*DW +: DW] = v;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic do_reset();
        rst = 1'b1;
        drive('0, '0);
        tick();
        tick();
        rst = 1'b0;
        q_out.delete();
    endtask
    initial begin
        do_reset();
        chk("rst_data", 64'(data_out), 0);
        chk("rst_valid", 64'(valid_out), 0);
        chk("rst_frame", 64'(frame_done), 0);
        chk("rst_sat", 64'(sat_flag), 0);
        chk("rst_ovf", 64'(ovf_err), 0);
        // all ones -> 6 after three cycles
        drive('1, 24'd1);
        tick();
        drive('0, '0);
        tick();
        chk("lat_early", 64'(valid_out), 0);
        tick();
        chk("lat_valid", 64'(valid_out), 1);
        chk("lat_data", 64'(data_out), 6);
        chk("lat_sat", 64'(sat_flag), 0);
        chk("lat_ovf", 64'(ovf_err), 0);
        chk("lat_frame", 64'(frame_done), 0);
        tick();
        chk("hold_valid", 64'(valid_out), 0);
        chk("hold_data", 64'(data_out), 6);
        // skewed channel 5 arrives three cycles late
        do_reset();
        base = nvalid;
        drive(6'b011111, 24'd2);
        tick();
        drive('0, '0);
        tick();
        tick();
        drive(6'b100000, 24'hFFFFFF);
        tick();
        drive('0, '0);
        tick();
        chk("skew_early", 64'(nvalid - base), 0);
        tick();
        chk("skew_valid", 64'(valid_out), 1);
        chk("skew_data", 64'(data_out), 9);
        tick();
        chk("skew_count", 64'(nvalid - base), 1);
        // positive saturation
        do_reset();
        drive('1, 24'h7FFFFF);
        tick();
        drive('0, '0);
        tick();
        tick();
        chk("satp_valid", 64'(valid_out), 1);
        chk("satp_data", 64'(data_out), 64'h7FFFFF);
        chk("satp_flag", 64'(sat_flag), 1);
        // negative saturation then ReLU
        do_reset();
        chk("satn_clr", 64'(sat_flag), 0);
        drive('1, 24'h800000);
        tick();
        drive('0, '0);
        tick();
        tick();
        chk("satn_valid", 64'(valid_out), 1);
        chk("satn_data", 64'(data_out), 0);
        chk("satn_flag", 64'(sat_flag), 1);
        // back-to-back: +6 then -6 rectified, no saturation
        do_reset();
        drive('1, 24'd1);
        tick();
        drive('1, 24'hFFFFFF);
        tick();
        drive('0, '0);
        tick();
        chk("b2b_d0", 64'(data_out), 6);
        tick();
        chk("b2b_v1", 64'(valid_out), 1);
        chk("b2b_d1", 64'(data_out), 0);
        chk("b2b_sat", 64'(sat_flag), 0);
        // channel 0 overruns its FIFO
        do_reset();
        base = nvalid;
        for (int i = 1; i <= 5; i++) begin
            drive(6'b000001, 24'(i));
            tick();
        end
        drive('0, '0);
        tick();
        tick();
        chk("ovf_flag", 64'(ovf_err), 1);
        chk("ovf_nout", 64'(nvalid - base), 0);
        for (int i = 0; i < 4; i++) begin
            drive(6'b111110, 24'd10);
            tick();
        end
        drive('0, '0);
        for (int i = 0; i < 5; i++) tick();
        chk("ovf_outs", 64'(q_out.size()), 4);
        for (int i = 0; i < 4 && i < q_out.size(); i++) chk($sformatf("ovf_d%0d", i), 64'(q_out[i][DW-1:0]), 64'(51 + i));
        chk("ovf_sticky", 64'(ovf_err), 1);
        // frames of four outputs
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            drive('1, 24'(i));
            tick();
        end
        drive('0, '0);
        for (int i = 0; i < 4; i++) tick();
        chk("frm_outs", 64'(q_out.size()), 9);
        for (int i = 0; i < 9 && i < q_out.size(); i++) begin
            chk($sformatf("frm_fd%0d", i), 64'(q_out[i][DW]), 64'(i == 3 || i == 7));
            chk($sformatf("frm_d%0d", i), 64'(q_out[i][DW-1:0]), 64'(6 * (i + 1)));
        end
        // reset with results in flight
        base = nvalid;
        drive('1, 24'd1);
        tick();
        drive('1, 24'd2);
        tick();
        rst = 1'b1;
        drive('1, 24'd3);
        tick();
        rst = 1'b0;
        drive('0, '0);
        chk("mid_data", 64'(data_out), 0);
        chk("mid_valid", 64'(valid_out), 0);
        chk("mid_frame", 64'(frame_done), 0);
        tick();
        tick();
        tick();
        chk("mid_stale", 64'(nvalid - base), 0);
        drive('1, 24'd4);
        tick();
        drive('0, '0);
        tick();
        chk("mid_early", 64'(valid_out), 0);
        tick();
        chk("mid_valid2", 64'(valid_out), 1);
        chk("mid_data2", 64'(data_out), 24);
        chk("mid_count", 64'(nvalid - base), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
